wb_cmd_master: RTL and testbench

Wishbone initiator for the S3 FPGA fabric: converts single-transaction commands from a simple valid/ready port into Wishbone read or write cycles on the WBs_* bus and returns read data and status on a valid/ready response port. It is the initiator end of the bus that the fabric IP blocks respond to. Typical uses are a UART command bridge or a DMA sequencer driving registers inside the fabric. A built-in timeout guarantees every command produces a response, even when no responder acknowledges.

---
 rtl/wb_cmd_master.sv | 157 +++++++++++++++
 tb/tb_wb_cmd_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Brief    : Wishbone initiator. Turns one valid/ready command at a time into
//            a Wishbone read or write cycle and returns data/status on a
//            valid/ready response port. A cycle timeout guarantees a response.
// Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_master #(
  parameter int                  ADDRWIDTH          = 17,
  parameter int                  DATAWIDTH          = 32,
  parameter int                  TIMEOUT_CNTR_WIDTH = 8,
  parameter int                  TIMEOUT_CYCLES     = 255,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_READ_VALUE = 32'hBAD_FAB_AC
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RSTn,
  // command port
  input  logic                 CMD_VALID_i,
  output logic                 CMD_READY_o,
  input  logic                 CMD_WE_i,
  input  logic [ADDRWIDTH-1:0] CMD_ADR_i,
  input  logic [3:0]           CMD_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] CMD_WR_DAT_i,
  // response port
  output logic                 RSP_VALID_o,
  input  logic                 RSP_READY_i,
  output logic [DATAWIDTH-1:0] RSP_RD_DAT_o,
  output logic                 RSP_ERR_o,
  // Wishbone initiator side
  output logic [ADDRWIDTH-1:0] WBs_ADR_o,
  output logic                 WBs_CYC_o,
  output logic                 WBs_STB_o,
  output logic                 WBs_WE_o,
  output logic                 WBs_RD_o,
  output logic [3:0]           WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBs_WR_DAT_o,
  input  logic [DATAWIDTH-1:0] WBs_RD_DAT_i,
  input  logic                 WBs_ACK_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Counter value seen on the last allowed BUS cycle; the counter starts at 0
  // in the first BUS cycle, so CYC is high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] c_TIMEOUT_LAST =
    TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] c_CNT_MAX = '1;

  state_t                        r_state;
  logic [TIMEOUT_CNTR_WIDTH-1:0] r_cnt;
  logic                          r_cmd_ready;
  logic                          r_rsp_valid;
  logic [DATAWIDTH-1:0]          r_rsp_dat;
  logic                          r_rsp_err;
  logic [ADDRWIDTH-1:0]          r_adr;
  logic                          r_cyc;
  logic                          r_we;      // latched command direction
  logic                          r_wbs_we;
  logic                          r_wbs_rd;
  logic [3:0]                    r_bstb;
  logic [DATAWIDTH-1:0]          r_wdat;

  // Single-process FSM: all outputs are registered and change only on state moves.
  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_adr       <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_wbs_we    <= 1'b0;
      r_wbs_rd    <= 1'b0;
      r_bstb      <= '0;
      r_wdat      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CMD_VALID_i) begin
            r_adr       <= CMD_ADR_i;
            r_bstb      <= CMD_BYTE_STB_i;
            r_wdat      <= CMD_WR_DAT_i;
            r_we        <= CMD_WE_i;
            r_wbs_we    <= CMD_WE_i;
            r_wbs_rd    <= ~CMD_WE_i;
            r_cyc       <= 1'b1;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_state     <= S_BUS;
          end
        end

        S_BUS: begin
          // ACK takes priority over a timeout on the same edge.
          if (WBs_ACK_i) begin
            r_rsp_dat   <= r_we ? '0 : WBs_RD_DAT_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_cyc       <= 1'b0;
            r_wbs_we    <= 1'b0;
            r_wbs_rd    <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            r_rsp_dat   <= r_we ? '0 : TIMEOUT_READ_VALUE;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_cyc       <= 1'b0;
            r_wbs_we    <= 1'b0;
            r_wbs_rd    <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (RSP_READY_i) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cyc       <= 1'b0;
          r_wbs_we    <= 1'b0;
          r_wbs_rd    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign CMD_READY_o    = r_cmd_ready;
  assign RSP_VALID_o    = r_rsp_valid;
  assign RSP_RD_DAT_o   = r_rsp_dat;
  assign RSP_ERR_o      = r_rsp_err;
  assign WBs_ADR_o      = r_adr;
  assign WBs_CYC_o      = r_cyc;
  assign WBs_STB_o      = r_cyc;
  assign WBs_WE_o       = r_wbs_we;
  assign WBs_RD_o       = r_wbs_rd;
  assign WBs_BYTE_STB_o = r_bstb;
  assign WBs_WR_DAT_o   = r_wdat;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Brief    : Self-checking bench for wb_cmd_master with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

  localparam int          TO  = 7;
  localparam logic [31:0] TOV = 32'hBAD_FAB_AC;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_we, rsp_ready, wb_ack;
  logic [16:0] cmd_adr;
  logic [3:0]  cmd_bstb;
  logic [31:0] cmd_wdat, wb_rd_dat;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_dat, wb_wdat;
  logic [16:0] wb_adr;
  logic        wb_cyc, wb_stb, wb_we, wb_rd;
  logic [3:0]  wb_bstb;

  int   vectors     = 0;
  int   miscompares = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  wb_cmd_master #(
    .ADDRWIDTH(17), .DATAWIDTH(32), .TIMEOUT_CNTR_WIDTH(8),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_READ_VALUE(TOV)
  ) dut (
    .WB_CLK(clk), .WB_RSTn(rst_n),
    .CMD_VALID_i(cmd_valid), .CMD_READY_o(cmd_ready), .CMD_WE_i(cmd_we),
    .CMD_ADR_i(cmd_adr), .CMD_BYTE_STB_i(cmd_bstb), .CMD_WR_DAT_i(cmd_wdat),
    .RSP_VALID_o(rsp_valid), .RSP_READY_i(rsp_ready),
    .RSP_RD_DAT_o(rsp_dat), .RSP_ERR_o(rsp_err),
    .WBs_ADR_o(wb_adr), .WBs_CYC_o(wb_cyc), .WBs_STB_o(wb_stb),
    .WBs_WE_o(wb_we), .WBs_RD_o(wb_rd), .WBs_BYTE_STB_o(wb_bstb),
    .WBs_WR_DAT_o(wb_wdat), .WBs_RD_DAT_i(wb_rd_dat), .WBs_ACK_i(wb_ack)
  );

  // One complete transaction: push expectation, drive the command, act as
  // responder (ACK on bus cycle ack_at, 0 = never), then consume the response.
  task automatic run_txn(input logic we, input logic [16:0] adr,
                         input logic [3:0] bstb, input logic [31:0] wdat,
                         input int ack_at, input logic [31:0] rdat,
                         output int cyc_cnt, output int lat, output logic bus_ok,
                         output logic [31:0] got_dat, output logic got_err,
                         output logic [31:0] exp_dat, output logic exp_err);
    rsp_t e;
    rsp_t p;
    e.err = !(ack_at >= 1 && ack_at <= TO);
    e.dat = we ? 32'h0 : (e.err ? TOV : rdat);
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_bstb = bstb; cmd_wdat = wdat;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_adr = ~adr; cmd_wdat = ~wdat; cmd_bstb = ~bstb;
    cyc_cnt = 0; lat = 1; bus_ok = 1'b1;
    for (int i = 0; i < 40 && wb_cyc === 1'b1; i++) begin
      cyc_cnt++;
      if (wb_stb !== 1'b1 || wb_we !== we || wb_rd !== !we || wb_adr !== adr ||
          wb_bstb !== bstb || wb_wdat !== wdat || rsp_valid !== 1'b0)
        bus_ok = 1'b0;
      wb_ack    = (cyc_cnt == ack_at);
      wb_rd_dat = wb_ack ? rdat : 32'hDEAD_0000 + 32'(cyc_cnt);
      @(negedge clk);
      lat++;
    end
    wb_ack = 1'b0;
    for (int i = 0; i < 5 && rsp_valid !== 1'b1; i++) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid === 1'b1 && wb_cyc === 1'b0 && wb_we === 1'b0 && wb_rd === 1'b0) begin
      got_dat = rsp_dat; got_err = rsp_err;
    end else begin
      got_dat = 'x; got_err = 1'bx;
    end
    p = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    exp_dat = p.dat; exp_err = p.err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_bstb = 0; cmd_wdat = 0;
    rsp_ready = 0; wb_ack = 0; wb_rd_dat = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_rsp: got rdy=%b vld=%b err=%b dat=%h want 1 0 0 0",
               cmd_ready, rsp_valid, rsp_err, rsp_dat);
    end
    vectors++;
    if ({wb_adr, wb_cyc, wb_stb, wb_we, wb_rd, wb_bstb, wb_wdat} !== '0) begin
      miscompares++;
      $display("FAIL reset_wb: got adr=%h cyc=%b stb=%b we=%b rd=%b bs=%h wd=%h want all 0",
               wb_adr, wb_cyc, wb_stb, wb_we, wb_rd, wb_bstb, wb_wdat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || wb_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b cyc=%b want 1 0", cmd_ready, wb_cyc);
    end
  endtask

  task automatic test_write_zero_wait();
    int cc, lat; logic ok, ge, ee; logic [31:0] gd, ed;
    run_txn(1'b1, 17'h01004, 4'hF, 32'hA5A5_0001, 1, 32'h1357_9BDF,
            cc, lat, ok, gd, ge, ed, ee);
    vectors++;
    if (cc !== 1 || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_bus: got cyc_cycles=%0d bus_ok=%b want 1 1", cc, ok);
    end
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL wr_latency: got %0d want 2", lat);
    end
    vectors++;
    if (gd !== ed || ge !== ee) begin
      miscompares++;
      $display("FAIL wr_rsp: got dat=%h err=%b want dat=%h err=%b", gd, ge, ed, ee);
    end
  endtask

  task automatic test_read_wait();
    int cc, lat; logic ok, ge, ee; logic [31:0] gd, ed;
    run_txn(1'b0, 17'h00000, 4'hF, 32'h0, 4, 32'h0000_ABCD,
            cc, lat, ok, gd, ge, ed, ee);
    vectors++;
    if (cc !== 4 || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_bus: got cyc_cycles=%0d bus_ok=%b want 4 1", cc, ok);
    end
    vectors++;
    if (gd !== ed || ge !== ee) begin
      miscompares++;
      $display("FAIL rd_rsp: got dat=%h err=%b want dat=%h err=%b", gd, ge, ed, ee);
    end
  endtask

  task automatic test_timeout();
    int cc, lat; logic ok, ge, ee; logic [31:0] gd, ed;
    // no ACK at all
    run_txn(1'b0, 17'h1FFFC, 4'h3, 32'h0, 0, 32'h0, cc, lat, ok, gd, ge, ed, ee);
    vectors++;
    if (cc !== TO || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL to_bus: got cyc_cycles=%0d bus_ok=%b want %0d 1", cc, ok, TO);
    end
    vectors++;
    if (gd !== ed || ge !== ee) begin
      miscompares++;
      $display("FAIL to_rsp: got dat=%h err=%b want dat=%h err=%b", gd, ge, ed, ee);
    end
    // ACK on the final allowed cycle beats the timeout
    run_txn(1'b0, 17'h00040, 4'hC, 32'h0, TO, 32'hC0DE_0007, cc, lat, ok, gd, ge, ed, ee);
    vectors++;
    if (cc !== TO || gd !== ed || ge !== ee) begin
      miscompares++;
      $display("FAIL to_ack_wins: got cyc=%0d dat=%h err=%b want cyc=%0d dat=%h err=%b",
               cc, gd, ge, TO, ed, ee);
    end
    // write that times out returns 0 with ERR
    run_txn(1'b1, 17'h00100, 4'h1, 32'h1111_2222, 0, 32'hFFFF_FFFF, cc, lat, ok, gd, ge, ed, ee);
    vectors++;
    if (cc !== TO || gd !== ed || ge !== ee) begin
      miscompares++;
      $display("FAIL to_write: got cyc=%0d dat=%h err=%b want cyc=%0d dat=%h err=%b",
               cc, gd, ge, TO, ed, ee);
    end
  endtask

  task automatic test_backpressure();
    rsp_t e, p;
    logic stable;
    int   cc;
    // first: zero-wait read
    e.err = 1'b0; e.dat = 32'h600D_F00D;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1; cmd_we = 0; cmd_adr = 17'h00200; cmd_bstb = 4'hF; cmd_wdat = 0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    wb_ack = 1; wb_rd_dat = 32'h600D_F00D;
    @(negedge clk);
    wb_ack = 0; wb_rd_dat = 0;
    // second command waiting while the response is held off
    cmd_valid = 1; cmd_we = 1; cmd_adr = 17'h00208; cmd_bstb = 4'h6; cmd_wdat = 32'hFEED_BEEF;
    p = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== p.dat || rsp_err !== p.err ||
          cmd_ready !== 1'b0 || wb_cyc !== 1'b0)
        stable = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (stable !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_hold: got vld=%b dat=%h err=%b rdy=%b cyc=%b want 1 %h %b 0 0",
               rsp_valid, rsp_dat, rsp_err, cmd_ready, wb_cyc, p.dat, p.err);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wb_cyc !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: got rdy=%b vld=%b cyc=%b want 1 0 0", cmd_ready, rsp_valid, wb_cyc);
    end
    e.err = 1'b0; e.dat = 32'h0;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 0;
    vectors++;
    if (wb_cyc !== 1'b1 || wb_we !== 1'b1 || wb_adr !== 17'h00208 ||
        wb_bstb !== 4'h6 || wb_wdat !== 32'hFEED_BEEF) begin
      miscompares++;
      $display("FAIL bp_second_start: got cyc=%b we=%b adr=%h bs=%h wd=%h want 1 1 00208 6 feedbeef",
               wb_cyc, wb_we, wb_adr, wb_bstb, wb_wdat);
    end
    cc = 0;
    while (wb_cyc === 1'b1 && cc < 20) begin
      cc++;
      wb_ack = (cc == 2); wb_rd_dat = 32'h7777_7777;
      @(negedge clk);
    end
    wb_ack = 0;
    p = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_dat !== p.dat || rsp_err !== p.err || cc !== 2) begin
      miscompares++;
      $display("FAIL bp_second_rsp: got vld=%b dat=%h err=%b cyc=%0d want 1 %h %b 2",
               rsp_valid, rsp_dat, rsp_err, cc, p.dat, p.err);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_spurious_ack();
    int cc, lat; logic ok, ge, ee; logic [31:0] gd, ed;
    run_txn(1'b0, 17'h00010, 4'hF, 32'h0, 2, 32'h5555_AAAA, cc, lat, ok, gd, ge, ed, ee);
    vectors++;
    if (gd !== ed || ge !== ee) begin
      miscompares++;
      $display("FAIL sp_pre_rsp: got dat=%h err=%b want dat=%h err=%b", gd, ge, ed, ee);
    end
    wb_ack = 1; wb_rd_dat = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    wb_ack = 0;
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wb_cyc !== 1'b0 ||
        rsp_dat !== 32'h5555_AAAA || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sp_idle_ack: got rdy=%b vld=%b cyc=%b dat=%h err=%b want 1 0 0 5555aaaa 0",
               cmd_ready, rsp_valid, wb_cyc, rsp_dat, rsp_err);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet;
    @(negedge clk);
    cmd_valid = 1; cmd_we = 0; cmd_adr = 17'h00ABC; cmd_bstb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    vectors++;
    if (wb_cyc !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_in_bus: got cyc=%b want 1", wb_cyc);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_async_drop: got cyc=%b stb=%b want 0 0", wb_cyc, wb_stb);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 1'b0, 32'h0} ||
        {wb_adr, wb_cyc, wb_stb, wb_we, wb_rd, wb_bstb, wb_wdat} !== '0) begin
      miscompares++;
      $display("FAIL rm_after_release: got rdy=%b vld=%b err=%b dat=%h adr=%h cyc=%b we=%b rd=%b want reset values",
               cmd_ready, rsp_valid, rsp_err, rsp_dat, wb_adr, wb_cyc, wb_we, wb_rd);
    end
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (quiet !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_no_response: got activity after reset, want none");
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_backpressure();
    test_spurious_ack();
    test_reset_mid();
    test_write_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
